// File: rtl/qp_param_loader_if.sv
// Word-stream handshake between the host and the QP parameter loader.
// The master drives data/valid; the loader (slave) answers with ready.
interface qp_param_loader_if #(
    parameter int W = 32
);
    logic [W-1:0] s_data;
    logic         s_valid;
    logic         s_ready;

    modport master (
        output s_data,
        output s_valid,
        input  s_ready
    );

    modport slave (
        input  s_data,
        input  s_valid,
        output s_ready
    );
endinterface

// File: rtl/qp_param_loader.sv
// Framed parameter writer for the LVI-PDNN QP network. Words are staged in a shadow
// buffer and reach the parameter bus only after a matching checksum.
module qp_param_loader #(
    parameter int N_PARAM = 113,
    parameter int W       = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load_start,
    input  logic                   run_stop,
    qp_param_loader_if.slave       stream,
    output logic [N_PARAM*W-1:0]   params,
    output logic                   net_en,
    output logic                   net_reset,
    output logic                   load_done,
    output logic                   load_err,
    output logic                   busy
);

    localparam int IDX_W = (N_PARAM > 1) ? $clog2(N_PARAM) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PARAM - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHECK,
        COMMIT,
        RUN
    } state_t;

    state_t state;
    state_t next_state;

    logic [W-1:0]     shadow [N_PARAM];
    logic [W-1:0]     active [N_PARAM];
    logic [IDX_W-1:0] idx;
    logic [W-1:0]     csum;

    logic handshake;
    logic do_clear;
    logic do_write;
    logic do_commit;
    logic do_error;

    assign handshake = stream.s_valid && stream.s_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // load_start wins over any same-cycle handshake or run_stop; COMMIT ignores it.
    always_comb begin
        next_state    = state;
        do_clear      = 1'b0;
        do_write      = 1'b0;
        do_commit     = 1'b0;
        do_error      = 1'b0;
        stream.s_ready = 1'b0;
        busy          = 1'b0;
        case (state)
            IDLE: begin
                if (load_start) begin
                    next_state = LOAD;
                    do_clear   = 1'b1;
                end
            end
            LOAD: begin
                stream.s_ready = 1'b1;
                busy           = 1'b1;
                if (load_start) begin
                    next_state = LOAD;
                    do_clear   = 1'b1;
                end else if (handshake) begin
                    do_write = 1'b1;
                    if (idx == LAST_IDX) begin
                        next_state = CHECK;
                    end
                end
            end
            CHECK: begin
                stream.s_ready = 1'b1;
                busy           = 1'b1;
                if (load_start) begin
                    next_state = LOAD;
                    do_clear   = 1'b1;
                end else if (handshake) begin
                    if (stream.s_data == csum) begin
                        next_state = COMMIT;
                        do_commit  = 1'b1;
                    end else begin
                        next_state = IDLE;
                        do_error   = 1'b1;
                    end
                end
            end
            COMMIT: begin
                busy       = 1'b1;
                next_state = RUN;
            end
            RUN: begin
                if (load_start) begin
                    next_state = LOAD;
                    do_clear   = 1'b1;
                end else if (run_stop) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx  <= '0;
            csum <= '0;
        end else if (do_clear) begin
            idx  <= '0;
            csum <= '0;
        end else if (do_write) begin
            csum <= csum + stream.s_data;
            if (idx != LAST_IDX) begin
                idx <= idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) begin
            shadow[idx] <= stream.s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < N_PARAM; i++) begin
                active[i] <= '0;
            end
        end else if (do_commit) begin
            for (int unsigned i = 0; i < N_PARAM; i++) begin
                active[i] <= shadow[i];
            end
        end
    end

    // Registered from next_state so net_reset leads net_en by exactly one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            net_en    <= 1'b0;
            net_reset <= 1'b0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            net_en    <= (next_state == RUN);
            net_reset <= (next_state == COMMIT);
            load_done <= (next_state == COMMIT);
            if (do_clear) begin
                load_err <= 1'b0;
            end else if (do_error) begin
                load_err <= 1'b1;
            end
        end
    end

    always_comb begin
        params = '0;
        for (int unsigned i = 0; i < N_PARAM; i++) begin
            params[i*W +: W] = active[i];
        end
    end

endmodule

// File: tb/tb_qp_param_loader.sv
// Directed bench for qp_param_loader: framing, checksum commit, restart, stop and reset.
module tb_qp_param_loader;

    localparam int N = 113;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           reset;
    logic           load_start;
    logic           run_stop;
    logic [N*W-1:0] params;
    logic           net_en;
    logic           net_reset;
    logic           load_done;
    logic           load_err;
    logic           busy;

    int passed = 0;
    int total  = 0;
    int hs_count = 0;

    qp_param_loader_if #(.W(W)) bus ();

    qp_param_loader #(
        .N_PARAM(N),
        .W(W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .load_start(load_start),
        .run_stop(run_stop),
        .stream(bus),
        .params(params),
        .net_en(net_en),
        .net_reset(net_reset),
        .load_done(load_done),
        .load_err(load_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.s_valid && bus.s_ready) hs_count++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: got %h expected %h", tag, obs, expv);
    endtask

    // mode 0: zeros, 1: i+1, 2: 0x00010000, 3: 0xFFFFFFFF
    function automatic logic [31:0] word_of(input int mode, input int i);
        case (mode)
            1:       return 32'(i + 1);
            2:       return 32'h0001_0000;
            3:       return 32'hFFFF_FFFF;
            default: return 32'h0;
        endcase
    endfunction

    task automatic check_params(input string tag, input int mode);
        logic [31:0] w;
        for (int i = 0; i < N; i++) begin
            w = params[i*W +: W];
            check($sformatf("%s[%0d]", tag, i), w, word_of(mode, i));
        end
    endtask

    task automatic send_word(input logic [31:0] d, input int gap);
        int n;
        bus.s_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            bus.s_data = $urandom;
            tick();
        end
        bus.s_data  = d;
        bus.s_valid = 1'b1;
        n = 0;
        while (!bus.s_ready && n < 20) begin
            tick();
            n++;
        end
        if (!bus.s_ready) check("ready_timeout", 32'(bus.s_ready), 32'd1);
        tick();
        bus.s_valid = 1'b0;
    endtask

    task automatic send_words(input int mode, input int count, input int maxgap);
        for (int i = 0; i < count; i++) begin
            send_word(word_of(mode, i), (maxgap > 0) ? $urandom_range(0, maxgap) : 0);
        end
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic pulse_stop();
        run_stop = 1'b1;
        tick();
        run_stop = 1'b0;
    endtask

    task automatic check_commit(input string tag, input int mode);
        check({tag, "_net_reset"}, 32'(net_reset), 32'd1);
        check({tag, "_load_done"}, 32'(load_done), 32'd1);
        check({tag, "_net_en_commit"}, 32'(net_en), 32'd0);
        check({tag, "_s_ready_commit"}, 32'(bus.s_ready), 32'd0);
        check({tag, "_busy_commit"}, 32'(busy), 32'd1);
        check({tag, "_load_err"}, 32'(load_err), 32'd0);
        check_params(tag, mode);
        tick();
        check({tag, "_net_reset_drop"}, 32'(net_reset), 32'd0);
        check({tag, "_load_done_drop"}, 32'(load_done), 32'd0);
        check({tag, "_net_en_run"}, 32'(net_en), 32'd1);
        check({tag, "_busy_run"}, 32'(busy), 32'd0);
        tick();
        check({tag, "_net_en_hold"}, 32'(net_en), 32'd1);
        check({tag, "_net_reset_once"}, 32'(net_reset), 32'd0);
    endtask

    task automatic check_all_low(input string tag);
        check({tag, "_s_ready"}, 32'(bus.s_ready), 32'd0);
        check({tag, "_net_en"}, 32'(net_en), 32'd0);
        check({tag, "_net_reset"}, 32'(net_reset), 32'd0);
        check({tag, "_load_done"}, 32'(load_done), 32'd0);
        check({tag, "_load_err"}, 32'(load_err), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int hs_base;
        reset       = 1'b1;
        load_start  = 1'b0;
        run_stop    = 1'b0;
        bus.s_data  = '0;
        bus.s_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check_all_low("reset");
        check_params("reset_params", 0);

        // Bad checksum: frame 1..113 with checksum one too high
        pulse_start();
        check("bad_busy_load", 32'(busy), 32'd1);
        check("bad_ready_load", 32'(bus.s_ready), 32'd1);
        send_words(1, N, 0);
        check("bad_ready_check", 32'(bus.s_ready), 32'd1);
        send_word(32'h0000_192A, 0);
        check("bad_load_err", 32'(load_err), 32'd1);
        check("bad_busy", 32'(busy), 32'd0);
        check("bad_net_en", 32'(net_en), 32'd0);
        check("bad_load_done", 32'(load_done), 32'd0);
        check("bad_net_reset", 32'(net_reset), 32'd0);
        check_params("bad_params", 0);
        tick();
        tick();
        check("bad_load_err_sticky", 32'(load_err), 32'd1);

        // Nominal frame; load_start clears the sticky error
        pulse_start();
        check("nom_load_err_clr", 32'(load_err), 32'd0);
        send_words(1, N, 0);
        check_params("nom_params_pending", 0);
        send_word(32'h0000_1929, 0);
        check_commit("nom", 1);

        // Reload while running: net_en drops, params held until commit
        pulse_start();
        check("reload_net_en", 32'(net_en), 32'd0);
        check("reload_busy", 32'(busy), 32'd1);
        send_words(2, 60, 0);
        check_params("reload_held", 1);
        send_words(2, N - 60, 0);
        check_params("reload_held_check", 1);
        send_word(32'h0071_0000, 0);
        check_commit("reload", 2);

        // run_stop in RUN, then in IDLE
        pulse_stop();
        check("stop_net_en", 32'(net_en), 32'd0);
        check("stop_busy", 32'(busy), 32'd0);
        check_params("stop_params", 2);
        pulse_stop();
        check("stop_idle_net_en", 32'(net_en), 32'd0);
        check("stop_idle_ready", 32'(bus.s_ready), 32'd0);
        check("stop_idle_busy", 32'(busy), 32'd0);

        // Backpressure: 0-5 idle cycles before every word
        hs_base = hs_count;
        pulse_start();
        send_words(1, N, 5);
        send_word(32'h0000_1929, $urandom_range(0, 5));
        check("bp_handshakes", 32'(hs_count - hs_base), 32'd114);
        check_commit("bp", 1);

        // Restart mid-load: 50 words of all-ones then a fresh good frame
        hs_base = hs_count;
        pulse_start();
        send_words(3, 50, 0);
        bus.s_data  = 32'hFFFF_FFFF;
        bus.s_valid = 1'b1;
        pulse_start();
        bus.s_valid = 1'b0;
        check("restart_ready", 32'(bus.s_ready), 32'd1);
        send_words(1, N, 0);
        send_word(32'h0000_1929, 0);
        check("restart_handshakes", 32'(hs_count - hs_base), 32'd165);
        check_commit("restart", 1);

        // Reset while in CHECK
        pulse_start();
        send_words(2, N, 0);
        check("rst_in_check_ready", 32'(bus.s_ready), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_all_low("rst_mid");
        check_params("rst_mid_params", 0);
        bus.s_data  = 32'h0071_0000;
        bus.s_valid = 1'b1;
        check("rst_csum_not_ready", 32'(bus.s_ready), 32'd0);
        tick();
        bus.s_valid = 1'b0;
        check_all_low("rst_after");
        check_params("rst_after_params", 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
